wb_pwm_ctrl: RTL and testbench
==============================

// Module: wb_pwm_ctrl
// PURPOSE
//  Multi-channel PWM generator with a Wishbone client register bank. Sits directly below the
//  FPGA top: consumes the WBs_* bus from the AHB-to-FPGA bridge and drives PWM outputs to io_pad.
//  Per-channel period/duty/polarity are set by the M4. Values are shadowed and take effect only
//  at a period boundary, so no glitched pulses occur.
// PARAMETERS
//  NUM_CH   4    number of PWM channels (1..4)
//  CNT_W    16   counter / PERIOD / DUTY width (bits)
// PORTS
//  WB_CLK        in   1       sole clock: Wishbone and PWM logic
//  WB_RST        in   1       synchronous, active-high reset
//  WBs_ADR       in   17      byte address; only [5:2] decoded
//  WBs_CYC       in   1       cycle / chip select
//  WBs_BYTE_STB  in   4       byte enables, honoured on writes
//  WBs_WE        in   1       write enable
//  WBs_RD        in   1       read enable (informational; read when CYC&STB&!WE)
//  WBs_STB       in   1       transfer strobe
//  WBs_WR_DAT    in   32      write data
//  WBs_RD_DAT    out  32      read data, valid only while WBs_ACK=1, else 0
//  WBs_ACK       out  1       single-cycle acknowledge
//  pwm_o         out  NUM_CH  registered PWM outputs
// BEHAVIOUR
//  Register map: channel n at byte offset n*0x10, with n = ADR[5:4].
//   +0x0 CTRL:   [0] EN, [1] POL; other bits read 0.
//   +0x4 PERIOD: [CNT_W-1:0].
//   +0x8 DUTY:   [CNT_W-1:0].
//   +0xC STATUS: RO; [CNT_W-1:0] live counter, [16] shadow-load-pending.
//   Channel index n>=NUM_CH: reads return 0, writes are ignored, the access is still ACKed.
//  Bus protocol:
//   - req = CYC & STB & !ACK. ACK goes high the cycle after req, for one cycle. Back-to-back
//     accesses therefore take 2 cycles each.
//   - A write commits on the clock edge where ACK is asserted, per byte lane.
//   - Reads are registered; RD_DAT is returned with ACK.
//   - Dropping CYC before ACK aborts the access: no ACK is issued and no write occurs.
//  Shadowing:
//   - Writes land in the CPU-visible register. A write to PERIOD or DUTY sets pending.
//   - Active copies (PER_A, DUT_A) load from the CPU-visible registers and clear pending when:
//     (a) EN=0 (every cycle), or (b) EN=1 and cnt==PER_A-1 (period wrap).
//  Counting and output:
//   - EN=1: cnt increments each cycle and wraps to 0 after PER_A-1.
//   - EN=0: cnt held at 0.
//   - active = EN & (PER_A!=0) & (cnt < DUT_A).
//   - pwm_o[n] = active ^ POL, registered, so 1 cycle latency from cnt.
//  Boundary cases:
//   - DUT_A=0: never active.
//   - DUT_A>=PER_A (PER_A!=0): always active, 100% duty.
//   - PER_A=0 with EN=1: output stays inactive and cnt holds 0.
//   - PER_A=1: cnt stays 0; active iff DUT_A>=1.
//   - Writing CTRL.EN 0->1: cnt starts at 0 on the next cycle. The first period uses the
//     values loaded while disabled.
//   - Writing EN 1->0: output goes to the inactive level (=POL) on the next pwm_o update.
//   - Write coinciding with wrap: the old CPU value loads into the active copy. The new value
//     stays pending and is used at the next wrap.
//  Reset values (WB_RST=1 at a clock edge, including mid-transfer or mid-period):
//   - All registers, shadows, counters and pending flags = 0.
//   - WBs_ACK=0, WBs_RD_DAT=0, pwm_o=0.
//   - Any in-flight access is dropped without ACK.
// TESTING
//  1 Reset: assert WB_RST for 3 cycles mid-write -> ACK=0, pwm_o=0, all regs read 0.
//  2 Ch0 PERIOD=10, DUTY=3, CTRL=1 -> pwm_o[0] high 3 cycles, low 7, repeating.
//    Checked over 5 periods.
//  3 Ch0 running 10/3, write DUTY=7 mid-period -> current period stays 3 high. Next period is
//    7 high. STATUS[16]=1 until the wrap, then 0.
//  4 Ch1 POL=1, EN=1, PERIOD=4, DUTY=4 -> pwm_o[1] constant 0 (inverted 100%).
//    DUTY=0 -> constant 1.
//  5 Bus: write 0x0000_1234 to ch2 PERIOD with BYTE_STB=4'b0001 -> readback 0x0034.
//    Each ACK is 1 cycle wide, 1 cycle after STB.
//  6 Read/write offset 0x30 with NUM_CH=3 -> ACK given, RD_DAT=0, no channel changes.
//    Disable ch0 while running -> pwm_o[0]=POL within 2 cycles.

Source files
------------

// File: rtl/wb_pwm_ctrl_if.sv
// Wishbone client bus bundle between the AHB-to-FPGA bridge and the PWM block.
interface wb_pwm_ctrl_if;
  logic [16:0] WBs_ADR;
  logic        WBs_CYC;
  logic [3:0]  WBs_BYTE_STB;
  logic        WBs_WE;
  logic        WBs_RD;
  logic        WBs_STB;
  logic [31:0] WBs_WR_DAT;
  logic [31:0] WBs_RD_DAT;
  logic        WBs_ACK;

  modport master (
    output WBs_ADR, WBs_CYC, WBs_BYTE_STB, WBs_WE, WBs_RD, WBs_STB, WBs_WR_DAT,
    input  WBs_RD_DAT, WBs_ACK
  );

  modport slave (
    input  WBs_ADR, WBs_CYC, WBs_BYTE_STB, WBs_WE, WBs_RD, WBs_STB, WBs_WR_DAT,
    output WBs_RD_DAT, WBs_ACK
  );
endinterface

// File: rtl/wb_pwm_ctrl.sv
// Multi-channel PWM generator with a Wishbone register bank; period/duty are
// shadowed and only take effect at a period boundary or while disabled.
module wb_pwm_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              WB_CLK,
  input  logic              WB_RST,
  wb_pwm_ctrl_if.slave      wbs,
  output logic [NUM_CH-1:0] pwm_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic              r_ack;
  logic [31:0]       r_rd_dat;
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_pol;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_pwm;
  logic [CNT_W-1:0]  r_per   [NUM_CH];
  logic [CNT_W-1:0]  r_dut   [NUM_CH];
  logic [CNT_W-1:0]  r_per_a [NUM_CH];
  logic [CNT_W-1:0]  r_dut_a [NUM_CH];
  logic [CNT_W-1:0]  r_cnt   [NUM_CH];

  logic              w_req;
  logic              w_wr;
  logic [1:0]        w_ch;
  logic [1:0]        w_off;
  logic [31:0]       w_rd_mux;
  logic [NUM_CH-1:0] w_last;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_active;
  logic              w_unused_bits;

  function automatic logic [CNT_W-1:0] merge_field(input logic [CNT_W-1:0] old_v,
                                                   input logic [31:0]      dat,
                                                   input logic [3:0]       be);
    logic [CNT_W-1:0] res;
    for (int b = 0; b < CNT_W; b++) res[b] = be[b/8] ? dat[b] : old_v[b];
    return res;
  endfunction

  assign w_ch  = wbs.WBs_ADR[5:4];
  assign w_off = wbs.WBs_ADR[3:2];
  // ACK is masked by CYC so a master that drops CYC aborts without a write.
  assign w_req = wbs.WBs_CYC & wbs.WBs_STB & ~r_ack;
  assign w_wr  = r_ack & wbs.WBs_CYC & wbs.WBs_WE;

  assign wbs.WBs_ACK    = r_ack & wbs.WBs_CYC;
  assign wbs.WBs_RD_DAT = (r_ack & wbs.WBs_CYC) ? r_rd_dat : 32'd0;
  assign pwm_o          = r_pwm;

  assign w_unused_bits = ^{wbs.WBs_RD, wbs.WBs_ADR[16:6], wbs.WBs_ADR[1:0], wbs.WBs_WR_DAT};

  always_comb begin
    w_rd_mux = 32'd0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (w_ch == 2'(n)) begin
        case (w_off)
          2'd0: w_rd_mux = {30'd0, r_pol[n], r_en[n]};
          2'd1: w_rd_mux[CNT_W-1:0] = r_per[n];
          2'd2: w_rd_mux[CNT_W-1:0] = r_dut[n];
          default: begin
            w_rd_mux[CNT_W-1:0] = r_cnt[n];
            w_rd_mux[16]        = r_pend[n];
          end
        endcase
      end
    end
  end

  always_comb begin
    w_last   = '0;
    w_load   = '0;
    w_active = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      // With PER_A=0 this compare never matches, so the shadow stays frozen until EN drops.
      w_last[n]   = (r_cnt[n] == r_per_a[n] - ONE);
      w_load[n]   = ~r_en[n] | w_last[n];
      w_active[n] = r_en[n] & (r_per_a[n] != '0) & (r_cnt[n] < r_dut_a[n]);
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_ack    <= 1'b0;
      r_rd_dat <= 32'd0;
    end else begin
      r_ack    <= w_req;
      r_rd_dat <= (w_req & ~wbs.WBs_WE) ? w_rd_mux : 32'd0;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      r_en   <= '0;
      r_pol  <= '0;
      r_pend <= '0;
      r_pwm  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_per[n]   <= '0;
        r_dut[n]   <= '0;
        r_per_a[n] <= '0;
        r_dut_a[n] <= '0;
        r_cnt[n]   <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        // Shadow load samples the CPU copy before this edge's write lands.
        if (w_load[n]) begin
          r_per_a[n] <= r_per[n];
          r_dut_a[n] <= r_dut[n];
        end

        if (~r_en[n] || (r_per_a[n] == '0) || w_last[n]) r_cnt[n] <= '0;
        else                                                r_cnt[n] <= r_cnt[n] + ONE;

        r_pwm[n] <= w_active[n] ^ r_pol[n];

        if (w_wr && (w_ch == 2'(n)) && ((w_off == 2'd1) || (w_off == 2'd2))) r_pend[n] <= 1'b1;
        else if (w_load[n])                                                  r_pend[n] <= 1'b0;

        if (w_wr && (w_ch == 2'(n))) begin
          case (w_off)
            2'd0: begin
              if (wbs.WBs_BYTE_STB[0]) begin
                r_en[n]  <= wbs.WBs_WR_DAT[0];
                r_pol[n] <= wbs.WBs_WR_DAT[1];
              end
            end
            2'd1: r_per[n] <= merge_field(r_per[n], wbs.WBs_WR_DAT, wbs.WBs_BYTE_STB);
            2'd2: r_dut[n] <= merge_field(r_dut[n], wbs.WBs_WR_DAT, wbs.WBs_BYTE_STB);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_pwm_ctrl.sv
// Scoreboard bench for wb_pwm_ctrl: a cycle reference model predicts ACK, read data
// and PWM outputs each cycle; a monitor pops and compares against the DUT.
module tb_wb_pwm_ctrl;
  localparam int NC = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] pwm;

  wb_pwm_ctrl_if bus();

  wb_pwm_ctrl #(.NUM_CH(NC), .CNT_W(CW)) dut (
    .WB_CLK (clk),
    .WB_RST (rst),
    .wbs    (bus),
    .pwm_o  (pwm)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic          ack;
    logic [31:0]   rd;
    logic [NC-1:0] pwm;
  } exp_t;

  exp_t q_exp[$];

  // Reference state: CPU-visible registers, active copies, phase within period.
  int            m_en[NC], m_pol[NC], m_per[NC], m_dut[NC], m_pend[NC];
  int            m_pa[NC], m_da[NC], m_cnt[NC];
  logic [NC-1:0] m_pwm;
  bit            m_ack;

  function automatic int merge(int old, logic [31:0] dat, logic [3:0] be);
    int r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = dat[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(int ch, int off);
    if (ch >= NC) return 32'd0;
    case (off)
      0:       return 32'(m_pol[ch] * 2 + m_en[ch]);
      1:       return 32'(m_per[ch]);
      2:       return 32'(m_dut[ch]);
      default: return 32'((m_pend[ch] << 16) | m_cnt[ch]);
    endcase
  endfunction

  initial begin : model
    exp_t        e;
    bit          req, cmt, ld;
    int          ch, off, t;
    logic [31:0] rdv;
    m_ack = 1'b0;
    m_pwm = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int n = 0; n < NC; n++) begin
          m_en[n] = 0; m_pol[n] = 0; m_per[n] = 0; m_dut[n] = 0; m_pend[n] = 0;
          m_pa[n] = 0; m_da[n] = 0; m_cnt[n] = 0;
        end
        m_ack = 1'b0;
        m_pwm = '0;
        e     = '0;
      end else begin
        req = bus.WBs_CYC && bus.WBs_STB && !m_ack;
        cmt = m_ack && bus.WBs_CYC && bus.WBs_WE;
        ch  = int'(bus.WBs_ADR[5:4]);
        off = int'(bus.WBs_ADR[3:2]);
        rdv = (req && !bus.WBs_WE) ? model_read(ch, off) : 32'd0;
        for (int n = 0; n < NC; n++) begin
          m_pwm[n] = ((m_en[n] != 0 && m_pa[n] != 0 && m_cnt[n] < m_da[n]) ? 1'b1 : 1'b0)
                     ^ m_pol[n][0];
          ld = (m_en[n] == 0) || (m_pa[n] != 0 && m_cnt[n] == m_pa[n] - 1);
          m_cnt[n] = (m_en[n] != 0 && m_pa[n] != 0) ? (m_cnt[n] + 1) % m_pa[n] : 0;
          if (ld) begin
            m_pa[n] = m_per[n];
            m_da[n] = m_dut[n];
            m_pend[n] = 0;
          end
        end
        if (cmt && ch < NC) begin
          case (off)
            0: begin
              t = merge(m_pol[ch] * 2 + m_en[ch], bus.WBs_WR_DAT, bus.WBs_BYTE_STB);
              m_en[ch]  = t & 1;
              m_pol[ch] = (t >> 1) & 1;
            end
            1: begin
              m_per[ch]  = merge(m_per[ch], bus.WBs_WR_DAT, bus.WBs_BYTE_STB) & 16'hFFFF;
              m_pend[ch] = 1;
            end
            2: begin
              m_dut[ch]  = merge(m_dut[ch], bus.WBs_WR_DAT, bus.WBs_BYTE_STB) & 16'hFFFF;
              m_pend[ch] = 1;
            end
            default: ;
          endcase
        end
        m_ack = req;
        e.ack = req;
        e.rd  = rdv;
        e.pwm = m_pwm;
      end
      q_exp.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() == 0) continue;
      e = q_exp.pop_front();
      vectors++;
      if ({bus.WBs_ACK, bus.WBs_RD_DAT, pwm} !== e) begin
        miscompares++;
        $display("FAIL cycle @%0t: ack=%0b rd=%h pwm=%b, required ack=%0b rd=%h pwm=%b",
                 $time, bus.WBs_ACK, bus.WBs_RD_DAT, pwm, e.ack, e.rd, e.pwm);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, act, req_v);
    end
  endtask

  task automatic bus_idle();
    bus.WBs_CYC      = 1'b0;
    bus.WBs_STB      = 1'b0;
    bus.WBs_WE       = 1'b0;
    bus.WBs_RD       = 1'b0;
    bus.WBs_ADR      = '0;
    bus.WBs_WR_DAT   = '0;
    bus.WBs_BYTE_STB = '0;
  endtask

  task automatic bus_xfer(bit we, int ch, int off, logic [31:0] dat, logic [3:0] be,
                          output logic [31:0] rdat);
    bit got;
    int lat;
    @(negedge clk);
    bus.WBs_ADR      = 17'((ch << 4) | (off << 2));
    bus.WBs_CYC      = 1'b1;
    bus.WBs_STB      = 1'b1;
    bus.WBs_WE       = we;
    bus.WBs_RD       = !we;
    bus.WBs_WR_DAT   = dat;
    bus.WBs_BYTE_STB = be;
    got  = 1'b0;
    lat  = 0;
    rdat = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (bus.WBs_ACK) begin
        got  = 1'b1;
        lat  = k;
        rdat = bus.WBs_RD_DAT;
      end
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    else      chk("ack_latency", 32'(lat), 32'd0);
    @(posedge clk);
    #1;
    if (got) chk("ack_width", 32'(bus.WBs_ACK), 32'd0);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wr(int ch, int off, logic [31:0] dat, logic [3:0] be = 4'hF);
    logic [31:0] dmy;
    bus_xfer(1'b1, ch, off, dat, be, dmy);
  endtask

  task automatic rd(int ch, int off, output logic [31:0] d);
    bus_xfer(1'b0, ch, off, 32'd0, 4'hF, d);
  endtask

  task automatic count_high(int ch, int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(pwm[ch]);
    end
  endtask

  initial begin : stim
    logic [31:0] d;
    int          c;
    bit          seen;
    logic        prev;
    bus_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset asserted in the middle of a write
    @(negedge clk);
    bus.WBs_ADR = 17'h4; bus.WBs_CYC = 1'b1; bus.WBs_STB = 1'b1; bus.WBs_WE = 1'b1;
    bus.WBs_WR_DAT = 32'd5; bus.WBs_BYTE_STB = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", 32'(bus.WBs_ACK), 32'd0);
      chk("rst_pwm", 32'(pwm), 32'd0);
    end
    rst = 1'b0;
    bus_idle();
    for (int ch = 0; ch < NC; ch++)
      for (int off = 0; off < 4; off++) begin
        rd(ch, off, d);
        chk($sformatf("rst_reg_ch%0d_off%0d", ch, off), d, 32'd0);
      end

    // Ch0 10/3
    wr(0, 1, 32'd10);
    wr(0, 2, 32'd3);
    wr(0, 0, 32'd1);
    count_high(0, 50, c);
    chk("ch0_10_3_highs", 32'(c), 32'd15);

    // Duty change mid-period, synchronised to a rising pwm edge
    seen = 1'b0;
    prev = pwm[0];
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (!prev && pwm[0]) seen = 1'b1;
      prev = pwm[0];
    end
    if (!seen) chk("ch0_rise_timeout", 32'd0, 32'd1);
    wr(0, 2, 32'd7);
    rd(0, 3, d);
    chk("ch0_pend_set", 32'(d[16]), 32'd1);
    repeat (12) @(negedge clk);
    rd(0, 3, d);
    chk("ch0_pend_clr", 32'(d[16]), 32'd0);
    count_high(0, 50, c);
    chk("ch0_10_7_highs", 32'(c), 32'd35);

    // Ch1 inverted full duty, then zero duty
    wr(1, 1, 32'd4);
    wr(1, 2, 32'd4);
    wr(1, 0, 32'd3);
    repeat (4) @(negedge clk);
    count_high(1, 20, c);
    chk("ch1_inv_full", 32'(c), 32'd0);
    wr(1, 2, 32'd0);
    repeat (10) @(negedge clk);
    count_high(1, 20, c);
    chk("ch1_inv_zero", 32'(c), 32'd20);

    // Byte lane write
    wr(2, 1, 32'h0000_1234, 4'b0001);
    rd(2, 1, d);
    chk("ch2_byte_lane", d, 32'h0000_0034);

    // Unimplemented channel 3
    wr(3, 0, 32'hFFFF_FFFF);
    wr(3, 1, 32'hFFFF_FFFF);
    rd(3, 0, d);
    chk("ch3_ctrl_zero", d, 32'd0);
    rd(3, 1, d);
    chk("ch3_per_zero", d, 32'd0);
    rd(0, 0, d);
    chk("ch0_ctrl_kept", d, 32'd1);
    rd(0, 2, d);
    chk("ch0_duty_kept", d, 32'd7);

    // Disable ch0 with POL=1
    wr(0, 0, 32'd2);
    @(posedge clk);
    #1;
    chk("ch0_disable_pol", 32'(pwm[0]), 32'd1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int          ch, off;
      bit          we;
      logic [31:0] dat;
      logic [3:0]  be;
      ch  = $urandom_range(0, 3);
      off = $urandom_range(0, 3);
      we  = $urandom_range(0, 1);
      dat = (off == 1 || off == 2) ? 32'($urandom_range(0, 12)) : $urandom;
      be  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      bus_xfer(we, ch, off, dat, be, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
